nios2_onchip_mem_arbiter: RTL and testbench
===========================================

Name: nios2_onchip_mem_arbiter

Overview:
- Shares the single-port 16000x32 on-chip RAM between two Avalon-MM style requesters: m0 (Nios II data master) and m1 (calculator accelerator / DMA).
- Grants at most one access per clock using round-robin priority.
- Drives the RAM's address, byteenable, chipselect, write and writedata.
- Returns read data to the owning requester with a fixed one-cycle latency.

Parameters:
- ADDR_W, 14, word address width of RAM and of both requesters.
- DATA_W, 32, data width.
- BE_W, 4, byteenable width (DATA_W/8).
- NUM_WORDS, 16000, populated RAM depth; word addresses >= NUM_WORDS are out of range.

Ports:
- clk  in  1  single system clock.
- reset  in  1  asynchronous, active-high reset.
- m0_address  in  ADDR_W  requester 0 word address.
- m0_byteenable  in  BE_W  requester 0 byte lanes.
- m0_read  in  1  requester 0 read request.
- m0_write  in  1  requester 0 write request.
- m0_writedata  in  DATA_W  requester 0 write data.
- m0_waitrequest  out  1  request not accepted this cycle.
- m0_readdata  out  DATA_W  read data.
- m0_readdatavalid  out  1  m0_readdata valid.
- m1_*  same set as m0_*, for requester 1.
- mem_address  out  ADDR_W  RAM address.
- mem_byteenable  out  BE_W  RAM byteenable.
- mem_chipselect  out  1  RAM chipselect.
- mem_write  out  1  RAM write.
- mem_writedata  out  DATA_W  RAM write data.
- mem_clken  out  1  RAM clock enable; constant 1.
- mem_readdata  in  DATA_W  RAM q; valid one cycle after the read address is presented.

Behaviour:
- Request definitions:
  - reqN = mN_read | mN_write.
  - If mN_read and mN_write are both high, the write wins and the read is ignored (no readdatavalid).
- Arbitration (combinational on reqN and register last_grant):
  - Only one requester active: it is granted.
  - Both active: the requester other than last_grant is granted.
  - last_grant updates to the granted index at each clk edge where a grant occurs; it is unchanged when idle.
- Waitrequest:
  - mN_waitrequest = reqN & ~grantN.
  - Never asserted when reqN = 0.
  - An accepted transfer completes in its grant cycle; zero wait states when uncontended.
- Memory drive:
  - mem_address, mem_byteenable and mem_writedata are muxed from the granted requester; from m0 when idle.
  - mem_chipselect = granted & in_range.
  - mem_write = granted write & in_range.
  - mem_byteenable is forced to all-ones for reads.
- Read return:
  - A granted read in cycle N sets rd_pending = 1, rd_owner = N-index and rd_oor = ~in_range at the edge ending cycle N.
  - In cycle N+1: mX_readdatavalid = rd_pending & (rd_owner == X).
  - mX_readdata = rd_oor ? 0 : mem_readdata, gated to 0 when not valid.
  - Back-to-back reads, including alternating owners, sustain one read per cycle; each readdatavalid is exactly one cycle wide.
- Out of range (address >= NUM_WORDS):
  - Accepted normally (waitrequest rules unchanged).
  - Write is dropped.
  - Read returns 0x00000000 with readdatavalid.
- Reset (asynchronous assert, synchronous-to-clk release):
  - last_grant = 1, so m0 wins the first contention.
  - rd_pending = 0, rd_owner = 0, rd_oor = 0.
  - Outputs during reset: readdatavalid = 0, readdata = 0, mem_chipselect = 0, mem_write = 0, waitrequest = reqN.
  - A read in flight when reset asserts is discarded; no readdatavalid after release.
- No internal buffering: the requester holds its request and signals while waitrequest = 1 (Avalon rule).

Test Plan:
- Reset then m0 read addr 0x0010 (RAM word = 0xDEADBEEF) → m0_waitrequest = 0 and mem_chipselect = 1 in cycle 0; m0_readdatavalid = 1 with 0xDEADBEEF in cycle 1; m1 outputs idle.
- m0 and m1 both request every cycle for 6 cycles after reset → grants m0, m1, m0, m1, m0, m1; the loser sees waitrequest = 1 each cycle; no cycle has both granted.
- m1 write 0x12345678 to 0x0100 with byteenable 4'b0011, then m0 read 0x0100 (prior word 0xAAAAAAAA) → m0 receives 0xAAAA5678.
- Alternating reads m0@0x5, m1@0x6, m0@0x7 on consecutive cycles → each readdatavalid is pulsed only on its owner in cycles 1, 2, 3 with the correct data.
- m0 write to 16000 and read from 16383 → mem_chipselect = 0 for both; the read returns 0x00000000 with readdatavalid; no RAM word changes.
- Assert reset in the cycle after an accepted m1 read → m1_readdatavalid never rises; after release, the first contended cycle grants m0.

Source files
------------

// File: rtl/nios2_onchip_mem_arbiter.sv
// Round-robin arbiter that shares one single-port on-chip RAM between two
// Avalon-MM requesters (m0: Nios II data master, m1: accelerator/DMA).
// At most one access is granted per clock. Read data returns to the owner
// exactly one cycle after the grant. Out-of-range accesses are accepted, but
// they never reach the RAM: writes are dropped and reads return zero.
module nios2_onchip_mem_arbiter #(
    parameter int          ADDR_W    = 14,
    parameter int          DATA_W    = 32,
    parameter int          BE_W      = DATA_W / 8,
    parameter int unsigned NUM_WORDS = 16000
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    // Arbitration and read-return state
    logic last_grant_q, last_grant_d;   // index of the most recent grant
    logic rd_pending_q, rd_pending_d;   // a read was granted last cycle
    logic rd_owner_q,   rd_owner_d;     // which requester owns that read
    logic rd_oor_q,     rd_oor_d;       // that read was out of range

    logic              req0, req1;
    logic              grant0, grant1, any_grant, sel;
    logic [ADDR_W-1:0] sel_address;
    logic [BE_W-1:0]   sel_byteenable;
    logic [DATA_W-1:0] sel_writedata;
    logic              sel_read, sel_write;
    logic              is_wr, is_rd, in_range;
    logic [DATA_W-1:0] ret_data;

    // Request decode and round-robin grant; nothing is granted while in reset
    always_comb begin
        req0   = m0_read | m0_write;
        req1   = m1_read | m1_write;
        grant0 = ~reset & req0 & (~req1 | last_grant_q);
        grant1 = ~reset & req1 & (~req0 | ~last_grant_q);
        any_grant = grant0 | grant1;
        sel       = grant1;
        m0_waitrequest = req0 & ~grant0;
        m1_waitrequest = req1 & ~grant1;
    end

    // Mux the granted requester onto the RAM port (m0 when idle)
    always_comb begin
        sel_address    = sel ? m1_address    : m0_address;
        sel_byteenable = sel ? m1_byteenable : m0_byteenable;
        sel_writedata  = sel ? m1_writedata  : m0_writedata;
        sel_read       = sel ? m1_read       : m0_read;
        sel_write      = sel ? m1_write      : m0_write;

        in_range = 32'(sel_address) < NUM_WORDS;
        // Write takes precedence when a requester raises both strobes
        is_wr    = any_grant & sel_write;
        is_rd    = any_grant & sel_read & ~sel_write;

        mem_address    = sel_address;
        mem_byteenable = is_rd ? {BE_W{1'b1}} : sel_byteenable;
        mem_writedata  = sel_writedata;
        mem_chipselect = any_grant & in_range;
        mem_write      = is_wr & in_range;
        mem_clken      = 1'b1;
    end

    // Next-state logic for grant history and the one-deep read return tag
    always_comb begin
        last_grant_d = any_grant ? sel : last_grant_q;
        rd_pending_d = is_rd;
        rd_owner_d   = is_rd ? sel       : rd_owner_q;
        rd_oor_d     = is_rd ? ~in_range : rd_oor_q;
    end

    // State registers; reset discards any read still in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            rd_pending_q <= 1'b0;
            rd_owner_q   <= 1'b0;
            rd_oor_q     <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
            rd_oor_q     <= rd_oor_d;
        end
    end

    // Steer RAM data to the owner; zero whenever not valid or out of range
    always_comb begin
        ret_data         = rd_oor_q ? '0 : mem_readdata;
        m0_readdatavalid = rd_pending_q & ~rd_owner_q;
        m1_readdatavalid = rd_pending_q &  rd_owner_q;
        m0_readdata      = m0_readdatavalid ? ret_data : '0;
        m1_readdata      = m1_readdatavalid ? ret_data : '0;
    end

endmodule

// File: tb/tb_nios2_onchip_mem_arbiter.sv
// Bench for nios2_onchip_mem_arbiter: directed vector table, hand-written
// out-of-range and reset-in-flight sequences, then constrained-random traffic
// checked against a transaction-level model of the arbiter and RAM.
module tb_nios2_onchip_mem_arbiter;

    localparam int NW = 16000;

    typedef struct packed {
        logic        r0, w0;
        logic [13:0] a0;
        logic [3:0]  be0;
        logic [31:0] d0;
        logic        r1, w1;
        logic [13:0] a1;
        logic [3:0]  be1;
        logic [31:0] d1;
    } in_t;

    typedef struct packed {
        logic        w0, w1, cs, we, v0, v1;
        logic [31:0] q0, q1;
        logic        chk_bus;
        logic [13:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
    } exp_t;

    typedef struct packed {
        in_t  i;
        exp_t e;
    } vec_t;

    typedef struct packed {
        logic        owner;
        logic [31:0] data;
    } ret_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] m0_address, m1_address, mem_address;
    logic [3:0]  m0_byteenable, m1_byteenable, mem_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata, mem_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata, mem_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic        mem_chipselect, mem_write, mem_clken;

    logic [31:0] tb_ram    [0:16383];
    logic [31:0] model_mem [0:NW-1];
    ret_t        ret_q[$];
    int          lg;
    int          n_vec  = 0;
    int          n_miss = 0;

    always #5 clk = ~clk;

    nios2_onchip_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable),
        .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable),
        .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata)
    );

    // Single-port RAM with registered read and byte-lane writes
    always @(posedge clk) begin
        if (mem_chipselect && mem_write)
            for (int b = 0; b < 4; b++)
                if (mem_byteenable[b])
                    tb_ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        mem_readdata <= tb_ram[mem_address];
    end

    function automatic logic [31:0] init_word(input int a);
        return 32'(a) * 32'h0001_0003 + 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~mask) | (d & mask);
    endfunction

    function automatic in_t mkin(input logic r0, input logic w0, input logic [13:0] a0,
                                 input logic [3:0] be0, input logic [31:0] d0,
                                 input logic r1, input logic w1, input logic [13:0] a1,
                                 input logic [3:0] be1, input logic [31:0] d1);
        in_t v;
        v = '{r0, w0, a0, be0, d0, r1, w1, a1, be1, d1};
        return v;
    endfunction

    function automatic exp_t mkexp(input logic w0, input logic w1, input logic cs,
                                   input logic we, input logic v0, input logic v1,
                                   input logic [31:0] q0, input logic [31:0] q1);
        exp_t e;
        e = '0;
        e.w0 = w0; e.w1 = w1; e.cs = cs; e.we = we;
        e.v0 = v0; e.v1 = v1; e.q0 = q0; e.q1 = q1;
        return e;
    endfunction

    task automatic chk(input string tag, input string what,
                       input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s %s: actual %08h required %08h", tag, what, act, req);
        end
    endtask

    task automatic apply(input in_t v);
        m0_read = v.r0; m0_write = v.w0; m0_address = v.a0;
        m0_byteenable = v.be0; m0_writedata = v.d0;
        m1_read = v.r1; m1_write = v.w1; m1_address = v.a1;
        m1_byteenable = v.be1; m1_writedata = v.d1;
    endtask

    task automatic model_reset();
        lg = 1;
        ret_q.delete();
    endtask

    // Transaction-level model: who wins, what the RAM sees, what comes back
    task automatic model_cycle(input in_t v, output exp_t e);
        bit          req0, req1, wr, rdop, inr;
        int          g;
        logic [13:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        ret_t        r;
        e = '0;
        e.chk_bus = 1'b1;
        if (ret_q.size() > 0) begin
            r = ret_q.pop_front();
            if (r.owner == 1'b0) begin e.v0 = 1'b1; e.q0 = r.data; end
            else                 begin e.v1 = 1'b1; e.q1 = r.data; end
        end
        req0 = v.r0 | v.w0;
        req1 = v.r1 | v.w1;
        if (req0 && req1) g = (lg == 0) ? 1 : 0;
        else if (req0)    g = 0;
        else if (req1)    g = 1;
        else              g = -1;
        e.w0 = req0 && (g != 0);
        e.w1 = req1 && (g != 1);
        if (g < 0) begin
            e.addr = v.a0; e.be = v.be0; e.wd = v.d0;
        end else begin
            addr = (g == 1) ? v.a1  : v.a0;
            be   = (g == 1) ? v.be1 : v.be0;
            wd   = (g == 1) ? v.d1  : v.d0;
            wr   = (g == 1) ? v.w1  : v.w0;
            rdop = ((g == 1) ? v.r1 : v.r0) && !wr;
            inr  = int'(addr) < NW;
            e.addr = addr; e.wd = wd;
            e.be   = rdop ? 4'hF : be;
            e.cs   = inr;
            e.we   = wr && inr;
            if (wr && inr) model_mem[addr] = merge(model_mem[addr], wd, be);
            if (rdop) ret_q.push_back('{owner: g[0], data: inr ? model_mem[addr] : 32'h0});
            lg = g;
        end
    endtask

    task automatic compare(input string tag, input exp_t e);
        n_vec++;
        chk(tag, "m0_waitrequest",   32'(m0_waitrequest),   32'(e.w0));
        chk(tag, "m1_waitrequest",   32'(m1_waitrequest),   32'(e.w1));
        chk(tag, "mem_chipselect",   32'(mem_chipselect),   32'(e.cs));
        chk(tag, "mem_write",        32'(mem_write),        32'(e.we));
        chk(tag, "m0_readdatavalid", 32'(m0_readdatavalid), 32'(e.v0));
        chk(tag, "m1_readdatavalid", 32'(m1_readdatavalid), 32'(e.v1));
        chk(tag, "m0_readdata",      m0_readdata,           e.q0);
        chk(tag, "m1_readdata",      m1_readdata,           e.q1);
        chk(tag, "mem_clken",        32'(mem_clken),        32'h1);
        if (e.chk_bus) begin
            chk(tag, "mem_address",    32'(mem_address),    32'(e.addr));
            chk(tag, "mem_byteenable", 32'(mem_byteenable), 32'(e.be));
            chk(tag, "mem_writedata",  mem_writedata,       e.wd);
        end
    endtask

    // One clock: drive after the edge, check at the falling edge
    task automatic run_cycle(input string tag, input in_t v, input bit use_tbl,
                             input exp_t t, output exp_t m);
        @(posedge clk); #1;
        apply(v);
        @(negedge clk);
        model_cycle(v, m);
        compare(tag, use_tbl ? t : m);
    endtask

    task automatic reset_check(input string tag, input in_t v);
        n_vec++;
        chk(tag, "m0_waitrequest",   32'(m0_waitrequest),   32'(v.r0 | v.w0));
        chk(tag, "m1_waitrequest",   32'(m1_waitrequest),   32'(v.r1 | v.w1));
        chk(tag, "mem_chipselect",   32'(mem_chipselect),   32'h0);
        chk(tag, "mem_write",        32'(mem_write),        32'h0);
        chk(tag, "m0_readdatavalid", 32'(m0_readdatavalid), 32'h0);
        chk(tag, "m1_readdatavalid", 32'(m1_readdatavalid), 32'h0);
        chk(tag, "m0_readdata",      m0_readdata,           32'h0);
        chk(tag, "m1_readdata",      m1_readdata,           32'h0);
    endtask

    task automatic rnd_side(output logic r, output logic w, output logic [13:0] a,
                            output logic [3:0] be, output logic [31:0] d);
        int k;
        k = int'($urandom_range(0, 3));
        r = (k == 1) || (k == 3);
        w = (k == 2) || (k == 3);
        k = int'($urandom_range(0, 9));
        if (k < 7)       a = 14'($urandom_range(0, 63));
        else if (k == 7) a = 14'($urandom_range(15990, 15999));
        else             a = 14'($urandom_range(16000, 16383));
        be = 4'($urandom_range(0, 15));
        d  = $urandom;
    endtask

    initial begin
        vec_t tbl[$];
        in_t  idle, v;
        exp_t m, none;
        bit   hold0, hold1;

        idle = '0;
        none = '0;
        for (int a = 0; a < 16384; a++) tb_ram[a] = init_word(a);
        for (int a = 0; a < NW; a++)    model_mem[a] = init_word(a);
        tb_ram[5]     = 32'h0505_0505; model_mem[5]     = 32'h0505_0505;
        tb_ram[6]     = 32'h0606_0606; model_mem[6]     = 32'h0606_0606;
        tb_ram[7]     = 32'h0707_0707; model_mem[7]     = 32'h0707_0707;
        tb_ram[16]    = 32'hDEAD_BEEF; model_mem[16]    = 32'hDEAD_BEEF;
        tb_ram[256]   = 32'hAAAA_AAAA; model_mem[256]   = 32'hAAAA_AAAA;

        // Directed table: contention, single read, partial write, alternating reads
        for (int k = 0; k < 6; k++)
            tbl.push_back('{mkin(1,0,14'd5,4'h0,0, 1,0,14'd6,4'h0,0),
                            mkexp(k[0], !k[0], 1, 0,
                                  (k > 0) && k[0], (k > 0) && !k[0],
                                  ((k > 0) && k[0])  ? 32'h0505_0505 : 32'h0,
                                  ((k > 0) && !k[0]) ? 32'h0606_0606 : 32'h0)});
        tbl.push_back('{idle, mkexp(0,0,0,0, 0,1, 32'h0, 32'h0606_0606)});
        tbl.push_back('{mkin(1,0,14'h10,4'h0,0, 0,0,0,4'h0,0),
                        mkexp(0,0,1,0, 0,0, 32'h0, 32'h0)});
        tbl.push_back('{mkin(0,0,0,4'h0,0, 0,1,14'h100,4'b0011,32'h1234_5678),
                        mkexp(0,0,1,1, 1,0, 32'hDEAD_BEEF, 32'h0)});
        tbl.push_back('{mkin(1,0,14'h100,4'h0,0, 0,0,0,4'h0,0),
                        mkexp(0,0,1,0, 0,0, 32'h0, 32'h0)});
        tbl.push_back('{mkin(1,0,14'h5,4'h0,0, 0,0,0,4'h0,0),
                        mkexp(0,0,1,0, 1,0, 32'hAAAA_5678, 32'h0)});
        tbl.push_back('{mkin(0,0,0,4'h0,0, 1,0,14'h6,4'h0,0),
                        mkexp(0,0,1,0, 1,0, 32'h0505_0505, 32'h0)});
        tbl.push_back('{mkin(1,0,14'h7,4'h0,0, 0,0,0,4'h0,0),
                        mkexp(0,0,1,0, 0,1, 32'h0, 32'h0606_0606)});
        tbl.push_back('{idle, mkexp(0,0,0,0, 1,0, 32'h0707_0707, 32'h0)});

        // Reset with both requesters active
        reset = 1'b1;
        v = mkin(1,0,14'h10,4'hF,0, 0,1,14'h20,4'hF,32'hFFFF_FFFF);
        apply(v);
        model_reset();
        @(negedge clk);
        reset_check("reset", v);
        @(posedge clk); #1;
        reset = 1'b0;
        apply(idle);

        foreach (tbl[k])
            run_cycle($sformatf("tbl%0d", k), tbl[k].i, 1'b1, tbl[k].e, m);

        // Out of range: write to 16000 and read from 16383
        run_cycle("oor_wr", mkin(0,1,14'd16000,4'hF,32'hFFFF_FFFF, 0,0,0,4'h0,0), 1'b0, none, m);
        run_cycle("oor_rd", mkin(1,0,14'd16383,4'h0,0, 0,0,0,4'h0,0), 1'b0, none, m);
        run_cycle("oor_ret", idle, 1'b0, none, m);
        n_vec++;
        chk("oor_ram", "ram[16000]", tb_ram[16000], init_word(16000));
        chk("oor_ram", "ram[16383]", tb_ram[16383], init_word(16383));

        // Reset lands in the cycle after an accepted m1 read
        run_cycle("flight_rd", mkin(0,0,0,4'h0,0, 1,0,14'h20,4'h0,0), 1'b0, none, m);
        @(posedge clk); #1;
        reset = 1'b1;
        v = mkin(1,0,14'h21,4'h0,0, 0,0,0,4'h0,0);
        apply(v);
        model_reset();
        @(negedge clk);
        reset_check("flight_rst0", v);
        @(posedge clk); #1;
        v = mkin(1,0,14'h21,4'h0,0, 1,0,14'h22,4'h0,0);
        apply(v);
        @(negedge clk);
        reset_check("flight_rst1", v);
        @(posedge clk); #1;
        reset = 1'b0;
        apply(idle);
        @(negedge clk);
        compare("flight_rel", mkexp(0,0,0,0, 0,0, 32'h0, 32'h0));
        run_cycle("flight_cont", v, 1'b1, mkexp(0,1,1,0, 0,0, 32'h0, 32'h0), m);
        model_cycle(v, m);      // keep the model's view of the grant history aligned
        lg = 0;
        ret_q.delete();
        ret_q.push_back('{owner: 1'b0, data: model_mem[14'h21]});
        run_cycle("flight_ret", idle, 1'b0, none, m);

        // Random traffic; a requester holds its request while stalled
        v = idle;
        hold0 = 1'b0;
        hold1 = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (!hold0) rnd_side(v.r0, v.w0, v.a0, v.be0, v.d0);
            if (!hold1) rnd_side(v.r1, v.w1, v.a1, v.be1, v.d1);
            run_cycle($sformatf("rnd%0d", n), v, 1'b0, none, m);
            hold0 = m.w0;
            hold1 = m.w1;
        end
        run_cycle("rnd_drain", idle, 1'b0, none, m);

        // RAM contents must match the model, and the unpopulated words stay untouched
        n_vec++;
        for (int a = 0; a < 64; a++)
            chk("ram_sweep", $sformatf("ram[%0d]", a), tb_ram[a], model_mem[a]);
        for (int a = 15990; a < NW; a++)
            chk("ram_sweep", $sformatf("ram[%0d]", a), tb_ram[a], model_mem[a]);
        for (int a = NW; a < 16384; a++)
            chk("ram_sweep", $sformatf("ram[%0d]", a), tb_ram[a], init_word(a));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
